// File: rtl/vga_source_select.sv
// Pixel source multiplexer with tear-free switching at frame start,
// optional colour-key overlay onto source 0 and timed auto-cycling.
module vga_source_select #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 RGB_W       = 12,
    parameter int                 HOLD_FRAMES = 60,
    parameter logic [RGB_W-1:0]   KEY_COLOR   = 12'h000,
    localparam int                SW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     p_tick,
    input  logic                     video_on,
    input  logic                     frame_start,
    input  logic [NUM_SRC*RGB_W-1:0] rgb_in,
    input  logic                     sel_next,
    input  logic                     sel_prev,
    input  logic                     sel_load,
    input  logic [SW-1:0]            sel_value,
    input  logic                     overlay_en,
    input  logic                     auto_cycle,
    output logic [RGB_W-1:0]         vga,
    output logic [SW-1:0]            cur_sel,
    output logic [SW-1:0]            pend_sel,
    output logic                     switch_pending
);

    localparam logic [SW-1:0] LAST_SRC  = SW'(NUM_SRC - 1);
    localparam logic [SW:0]   NUM_SRC_X = (SW + 1)'(NUM_SRC);
    localparam logic [9:0]    HOLD_LAST = 10'(HOLD_FRAMES - 1);

    logic [RGB_W-1:0] src [NUM_SRC];
    logic [RGB_W-1:0] src_pix;
    logic [RGB_W-1:0] pixel;
    logic [SW-1:0]    sel_inc;
    logic [SW-1:0]    sel_dec;
    logic [SW-1:0]    pend_nxt;
    logic [9:0]       frame_left;
    logic [9:0]       left_nxt;
    logic             frame_tick;
    logic             manual_req;
    logic             load_ok;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src[k] = rgb_in[k*RGB_W +: RGB_W];
    end

    assign frame_tick = p_tick & frame_start;
    assign manual_req = sel_load | sel_next | sel_prev;
    assign load_ok    = {1'b0, sel_value} < NUM_SRC_X;
    assign sel_inc    = (pend_sel == LAST_SRC) ? '0 : pend_sel + 1'b1;
    assign sel_dec    = (pend_sel == '0) ? LAST_SRC : pend_sel - 1'b1;

    assign src_pix = src[cur_sel];
    assign pixel   = (overlay_en && src_pix == KEY_COLOR) ? src[0] : src_pix;

    // Frames remaining before an auto advance; reloads whenever auto mode is
    // off or the user touches the selection, so manual input restarts the hold.
    always_comb begin
        pend_nxt = pend_sel;
        left_nxt = frame_left;
        if (!auto_cycle || manual_req) begin
            left_nxt = HOLD_LAST;
        end else if (frame_tick) begin
            if (frame_left == '0) begin
                left_nxt = HOLD_LAST;
                pend_nxt = sel_inc;
            end else begin
                left_nxt = frame_left - 1'b1;
            end
        end

        // An out-of-range load still blocks next/prev for that cycle.
        if (sel_load) begin
            if (load_ok) pend_nxt = sel_value;
        end else if (sel_next && !sel_prev) begin
            pend_nxt = sel_inc;
        end else if (sel_prev && !sel_next) begin
            pend_nxt = sel_dec;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            vga        <= '0;
            cur_sel    <= '0;
            pend_sel   <= '0;
            frame_left <= HOLD_LAST;
        end else begin
            pend_sel   <= pend_nxt;
            frame_left <= left_nxt;
            if (frame_tick) cur_sel <= pend_sel;
            if (p_tick) vga <= video_on ? pixel : '0;
        end
    end

    assign switch_pending = (pend_sel != cur_sel);

endmodule
